// File: rtl/fetch_pkg.sv
// fetch_pkg
//   Shared types and constants for the instruction fetch stage.
//   INST_W         : instruction word width
//   PC_INC         : PC step between sequential fetches (16-bit instructions)
//   fetch_entry_t  : buffered fetch record {pc, inst} for the default 16-bit address space
package fetch_pkg;

    localparam int INST_W         = 16;
    localparam int PC_INC         = 2;
    localparam int DEFAULT_ADDR_W = 16;

    typedef struct packed {
        logic [DEFAULT_ADDR_W-1:0] pc;
        logic [INST_W-1:0]         inst;
    } fetch_entry_t;

endpackage

// File: rtl/fetch_fifo.sv
// fetch_fifo
//   Small circular instruction buffer between the PC/imem side and decode.
//   Ports:
//     clk, rst_n    : clock, asynchronous active-low reset
//     push_i        : write push_data_i at the tail (ignored when full without a pop)
//     pop_i         : drop the head entry (ignored when empty)
//     flush_i       : discard all entries; wins over push and pop
//     push_data_i   : entry to store
//     head_o        : entry at the head (contents undefined when empty_o)
//     full_o        : DEPTH entries held
//     empty_o       : no entries held
module fetch_fifo
    import fetch_pkg::*;
#(
    parameter int  DEPTH   = 2,
    parameter type entry_t = fetch_entry_t
) (
    input  logic   clk,
    input  logic   rst_n,
    input  logic   push_i,
    input  logic   pop_i,
    input  logic   flush_i,
    input  entry_t push_data_i,
    output entry_t head_o,
    output logic   full_o,
    output logic   empty_o
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = PTR_W + 1;

    entry_t             mem_q [DEPTH];
    logic [PTR_W-1:0]   wrPtr_q, wrPtr_d;
    logic [PTR_W-1:0]   rdPtr_q, rdPtr_d;
    logic [CNT_W-1:0]   count_q, count_d;
    logic               doPush, doPop;

    assign full_o  = (count_q == CNT_W'(DEPTH));
    assign empty_o = (count_q == '0);
    assign head_o  = mem_q[rdPtr_q];

    // A push into a full buffer is only legal when the head leaves in the same cycle.
    assign doPush = push_i & ~flush_i & (~full_o | pop_i);
    assign doPop  = pop_i & ~flush_i & ~empty_o;

    // Pointer and occupancy bookkeeping; DEPTH is a power of two so pointers wrap naturally.
    always_comb begin
        wrPtr_d = wrPtr_q;
        rdPtr_d = rdPtr_q;
        count_d = count_q;
        if (flush_i) begin
            wrPtr_d = '0;
            rdPtr_d = '0;
            count_d = '0;
        end else begin
            if (doPush) wrPtr_d = wrPtr_q + PTR_W'(1);
            if (doPop)  rdPtr_d = rdPtr_q + PTR_W'(1);
            case ({doPush, doPop})
                2'b10:   count_d = count_q + CNT_W'(1);
                2'b01:   count_d = count_q - CNT_W'(1);
                default: count_d = count_q;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wrPtr_q <= '0;
            rdPtr_q <= '0;
            count_q <= '0;
        end else begin
            wrPtr_q <= wrPtr_d;
            rdPtr_q <= rdPtr_d;
            count_q <= count_d;
        end
    end

    // Storage needs no reset: an entry is only ever read after it has been written.
    always_ff @(posedge clk) begin
        if (doPush) mem_q[wrPtr_q] <= push_data_i;
    end

endmodule

// File: rtl/fetch_unit.sv
// fetch_unit
//   Instruction fetch stage: owns the PC, reads the zero-latency instruction memory,
//   buffers fetched words and hands {inst, pc, pc+2} to decode over valid/ready.
//   Optional feature macro: FETCH_PERF_EN adds perf_fetch_cnt / perf_stall_cnt.
//   Ports:
//     clk, rst_n                  : clock, asynchronous active-low reset
//     imem_addr/imem_en/imem_wr   : instruction memory request (addr = pc, wr always 0)
//     imem_data                   : instruction word for imem_addr, same cycle
//     stall_fetch                 : hold PC and stop pushing; buffer keeps draining
//     redirect_valid/redirect_pc  : flush buffer and restart at redirect_pc (bit 0 cleared)
//     inst_valid/inst_ready       : decode handshake on the buffer head
//     inst_data/inst_pc/inst_pc_plus2 : head entry, all zero while the buffer is empty
//     perf_fetch_cnt/perf_stall_cnt   : (FETCH_PERF_EN only) push count, no-fetch cycle count
module fetch_unit
    import fetch_pkg::*;
#(
    parameter int                    ADDR_WIDTH = 16,
    parameter logic [ADDR_WIDTH-1:0] RESET_PC   = '0,
    parameter int                    FIFO_DEPTH = 2
) (
    input  logic                  clk,
    input  logic                  rst_n,
    output logic [ADDR_WIDTH-1:0] imem_addr,
    output logic                  imem_en,
    output logic                  imem_wr,
    input  logic [INST_W-1:0]     imem_data,
    input  logic                  stall_fetch,
    input  logic                  redirect_valid,
    input  logic [ADDR_WIDTH-1:0] redirect_pc,
    output logic                  inst_valid,
    input  logic                  inst_ready,
    output logic [INST_W-1:0]     inst_data,
    output logic [ADDR_WIDTH-1:0] inst_pc,
    output logic [ADDR_WIDTH-1:0] inst_pc_plus2
`ifdef FETCH_PERF_EN
    ,
    output logic [31:0]           perf_fetch_cnt,
    output logic [31:0]           perf_stall_cnt
`endif
);

    typedef struct packed {
        logic [ADDR_WIDTH-1:0] pc;
        logic [INST_W-1:0]     inst;
    } entry_t;

    logic [ADDR_WIDTH-1:0] pc_q, pc_d;
    logic                  fifoFull, fifoEmpty;
    logic                  pop, fetchGo;
    entry_t                pushEntry, headEntry;

    // Redirect wins over everything; a full buffer can still take a word when the head leaves.
    assign pop       = ~fifoEmpty & inst_ready;
    assign fetchGo   = ~redirect_valid & ~stall_fetch & (~fifoFull | pop);
    assign imem_en   = fetchGo & rst_n;
    assign imem_addr = pc_q;
    assign imem_wr   = 1'b0;
    assign pushEntry = '{pc: pc_q, inst: imem_data};

    fetch_fifo #(
        .DEPTH   (FIFO_DEPTH),
        .entry_t (entry_t)
    ) u_fifo (
        .clk         (clk),
        .rst_n       (rst_n),
        .push_i      (fetchGo),
        .pop_i       (pop & ~redirect_valid),
        .flush_i     (redirect_valid),
        .push_data_i (pushEntry),
        .head_o      (headEntry),
        .full_o      (fifoFull),
        .empty_o     (fifoEmpty)
    );

    // Decode sees zeros rather than stale storage whenever nothing is buffered.
    assign inst_valid    = ~fifoEmpty;
    assign inst_data     = fifoEmpty ? '0 : headEntry.inst;
    assign inst_pc       = fifoEmpty ? '0 : headEntry.pc;
    assign inst_pc_plus2 = fifoEmpty ? '0 : headEntry.pc + ADDR_WIDTH'(PC_INC);

    // Next PC: redirect target (halfword aligned), else sequential step on a fetch.
    always_comb begin
        pc_d = pc_q;
        if (redirect_valid) begin
            pc_d = {redirect_pc[ADDR_WIDTH-1:1], 1'b0};
        end else if (fetchGo) begin
            pc_d = pc_q + ADDR_WIDTH'(PC_INC);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc_q <= RESET_PC;
        end else begin
            pc_q <= pc_d;
        end
    end

`ifdef FETCH_PERF_EN
    logic [31:0] perfFetch_q, perfStall_q;

    // Free-running event counters; they wrap silently at 2**32.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            perfFetch_q <= '0;
            perfStall_q <= '0;
        end else begin
            if (fetchGo) perfFetch_q <= perfFetch_q + 32'd1;
            else         perfStall_q <= perfStall_q + 32'd1;
        end
    end

    assign perf_fetch_cnt = perfFetch_q;
    assign perf_stall_cnt = perfStall_q;
`endif

endmodule
